regfile_wb_ctrl: RTL
====================

Name: regfile_wb_ctrl

Overview:
Writeback controller in front of the 64-bit integer register file. Owns the single register-file write port.
- After reset, runs a clear sweep that zeroes x1..x31.
- Then arbitrates two writeback requesters (ALU and load unit) onto that port with valid/ready handshakes.
- Drives the register-file write enable, destination and data through registered outputs.

Parameters:
XLEN, 64, data width of register values
NREGS, 32, number of architectural registers (x0 hard-wired zero)
REG_AW, 5, register index width, equal to log2(NREGS)

Ports:
i_clk  in  1  clock
i_resetn  in  1  asynchronous active-low reset
i_alu_valid  in  1  ALU writeback request
o_alu_ready  out  1  ALU request accepted this cycle
i_alu_rd  in  REG_AW  ALU destination register
i_alu_data  in  XLEN  ALU result
i_ld_valid  in  1  load writeback request
o_ld_ready  out  1  load request accepted this cycle
i_ld_rd  in  REG_AW  load destination register
i_ld_data  in  XLEN  load data
o_rf_we  out  1  register-file write enable
o_rf_rd  out  REG_AW  register-file write index
o_rf_data  out  XLEN  register-file write data
o_init_done  out  1  clear sweep complete, controller in RUN

Behaviour:
- Reset: i_resetn low asynchronously forces the following:
  - state=CLEAR, sweep counter=1, round-robin pointer=ALU (load wins the first tie).
  - o_rf_we=0, o_rf_rd=0, o_rf_data=0, o_init_done=0.
- CLEAR state:
  - Each cycle registers o_rf_we=1, o_rf_rd=counter, o_rf_data=0, then increments the counter.
  - After the write of index NREGS-1 is issued, transitions to RUN. The sweep takes 31 cycles.
  - o_init_done is registered and goes high on the cycle after the last sweep write is presented.
  - o_alu_ready=o_ld_ready=0 throughout; requester valids are ignored.
- RUN state:
  - At most one request is accepted per cycle.
  - Readies are combinational from the valids, the state and the pointer. A requester's ready is never asserted unless its own valid is high.
  - Only one requester valid: that requester gets ready=1.
  - Both valid: grant goes to the requester not granted last. The pointer updates on every accepted grant.
  - Accepting a request registers o_rf_we=(rd!=0), o_rf_rd=rd, o_rf_data=data on the next edge. Latency from accept to write is 1 cycle.
  - No accept in a cycle: o_rf_we=0 next cycle; o_rf_rd and o_rf_data hold their last value.
  - rd==0: the request is accepted (ready=1) but no write is issued.
- Handshake: a requester holds valid, rd and data stable until it sees ready; transfer occurs on valid&&ready at the clock edge.
- Same rd from both sources: writes land in grant order, one per cycle; the later grant overwrites.
- Reset mid-sweep or mid-run: an in-flight registered write is dropped (o_rf_we=0 immediately). Pending requests are not remembered; requesters must re-present them. The sweep restarts at x1.

Optional Feature:
Macro REGFILE_WB_CTRL_LOAD_PRIO_EN.
- Defined: fixed priority, load always beats ALU when both are valid; round-robin pointer logic is not built.
- Undefined: round-robin as above.
- CLEAR behaviour is identical in both builds.

Decomposition:
- Package regfile_ctrl_pkg:
  - XLEN, REG_AW, NREGS constants.
  - state_t enum {ST_CLEAR, ST_RUN}.
  - wb_req_t struct {valid, rd, data}.
- Sub-module rr_arb2: two-requester round-robin arbiter (req[1:0] -> gnt[1:0], pointer update on accept). It is bypassed when REGFILE_WB_CTRL_LOAD_PRIO_EN is defined.

Test Plan:
- Release reset with no requests -> 31 consecutive cycles of o_rf_we=1, o_rf_rd=1..31, o_rf_data=0; o_init_done=1 the following cycle; readies 0 throughout the sweep.
- After init, ALU valid with rd=5, data=0x0000_0000_DEAD_BEEF for one cycle -> o_alu_ready=1; next cycle o_rf_we=1, o_rf_rd=5, o_rf_data=0xDEADBEEF; the cycle after, o_rf_we=0.
- ALU (rd=3, data=0x11) and load (rd=4, data=0x22) both valid for 4 cycles -> grants L,A,L,A; writes rd=4,3,4,3 one cycle later each.
- Load valid with rd=0, data=0xFF -> o_ld_ready=1; o_rf_we stays 0.
- Assert i_resetn=0 mid-run while a write is registered -> o_rf_we=0 and o_init_done=0 immediately; after release, the sweep restarts at rd=1.
- REGFILE_WB_CTRL_LOAD_PRIO_EN defined, both requesters valid for 3 cycles -> o_ld_ready=1 all 3 cycles, o_alu_ready=0 all 3 cycles.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the integer register-file writeback controller.
package regfile_ctrl_pkg;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // ptr_q = 1 means the last accepted grant went to req_i[1].
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt_o) ptr_d = gnt_o[1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller owning the register-file write port: clear sweep of x1..x31,
// then ALU/load arbitration. Define REGFILE_WB_CTRL_LOAD_PRIO_EN for fixed load priority.
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_alu_valid,
  output logic              o_alu_ready,
  input  logic [REG_AW-1:0] i_alu_rd,
  input  logic [XLEN-1:0]   i_alu_data,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [REG_AW-1:0] i_ld_rd,
  input  logic [XLEN-1:0]   i_ld_data,
  output logic              o_rf_we,
  output logic [REG_AW-1:0] o_rf_rd,
  output logic [XLEN-1:0]   o_rf_data,
  output logic              o_init_done
);

  state_t            state_q;
  logic [REG_AW-1:0] cnt_q;
  logic              we_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   data_q;
  logic              init_q;

  wb_req_t alu_req;
  wb_req_t ld_req;
  wb_req_t sel_req;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       accept;

  assign alu_req.valid = i_alu_valid;
  assign alu_req.rd    = i_alu_rd;
  assign alu_req.data  = i_alu_data;
  assign ld_req.valid  = i_ld_valid;
  assign ld_req.rd     = i_ld_rd;
  assign ld_req.data   = i_ld_data;

  // Bit 0 is the ALU, bit 1 the load unit; nothing is requested during the sweep.
  assign req = {ld_req.valid, alu_req.valid} & {2{state_q == ST_RUN}};

`ifdef REGFILE_WB_CTRL_LOAD_PRIO_EN
  assign gnt = req[1] ? 2'b10 : req;
`else
  rr_arb2 u_arb (
    .clk_i  (i_clk),
    .rst_ni (i_resetn),
    .req_i  (req),
    .gnt_o  (gnt)
  );
`endif

  assign accept      = |gnt;
  assign sel_req     = gnt[1] ? ld_req : alu_req;
  assign o_alu_ready = gnt[0];
  assign o_ld_ready  = gnt[1];

  // The counter wraps to zero after x31 is written; that idle cycle hands over to RUN.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= ST_CLEAR;
      cnt_q   <= REG_AW'(1);
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        ST_CLEAR: begin
          if (cnt_q == '0) begin
            state_q <= ST_RUN;
            init_q  <= 1'b1;
          end else begin
            we_q   <= 1'b1;
            rd_q   <= cnt_q;
            data_q <= '0;
            cnt_q  <= cnt_q + REG_AW'(1);
          end
        end
        ST_RUN: begin
          if (accept) begin
            we_q   <= (sel_req.rd != '0);
            rd_q   <= sel_req.rd;
            data_q <= sel_req.data;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign o_rf_we     = we_q;
  assign o_rf_rd     = rd_q;
  assign o_rf_data   = data_q;
  assign o_init_done = init_q;

endmodule
